// File: rtl/eth_phy_reset_sequencer.sv
// Power-up and soft-reset sequencer for the MII 100Base-T top level.
// It holds the PHY reset pin low for a fixed time, waits for the PHY to
// settle, holds the Ethernet core in reset for a few extra cycles, and
// then reports RUN. In RUN, a soft request re-runs the whole sequence.
//
// Request semantics: i_soft_reset_req is a single-cycle pulse sampled on the
// rising edge of i_clock. It is accepted only when o_state reports RUN
// (o_ready=1). In any other state it is dropped, not queued, so a request
// cannot restart or extend a sequence that is already in progress.
module eth_phy_reset_sequencer #(
  parameter int p_CLOCK_FREQ_HZ     = 125000000,
  parameter int p_PHY_RESET_US      = 10000,
  parameter int p_PHY_SETTLE_US     = 5000,
  parameter int p_CORE_RESET_CYCLES = 16
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_soft_reset_req,
  output logic       o_phy_reset_n,
  output logic       o_core_reset,
  output logic       o_ready,
  output logic [1:0] o_state,
  output logic [7:0] o_seq_count
);

  localparam int lp_PHY_RST_CYCLES = p_CLOCK_FREQ_HZ / 1000000 * p_PHY_RESET_US;
  localparam int lp_SETTLE_CYCLES  = p_CLOCK_FREQ_HZ / 1000000 * p_PHY_SETTLE_US;

  localparam int lp_MAX_A  = (lp_PHY_RST_CYCLES > lp_SETTLE_CYCLES) ?
                             lp_PHY_RST_CYCLES : lp_SETTLE_CYCLES;
  localparam int lp_MAX    = (lp_MAX_A > p_CORE_RESET_CYCLES) ?
                             lp_MAX_A : p_CORE_RESET_CYCLES;
  localparam int lp_CNT_W  = $clog2(lp_MAX) + 1;

  localparam logic [lp_CNT_W-1:0] lp_PHY_LAST    = lp_CNT_W'(lp_PHY_RST_CYCLES - 1);
  localparam logic [lp_CNT_W-1:0] lp_SETTLE_LAST = lp_CNT_W'(lp_SETTLE_CYCLES - 1);
  localparam logic [lp_CNT_W-1:0] lp_CORE_LAST   = lp_CNT_W'(p_CORE_RESET_CYCLES - 1);

  // A zero-length phase would make the terminal compare unreachable.
  if (lp_PHY_RST_CYCLES < 1 || lp_SETTLE_CYCLES < 1 || p_CORE_RESET_CYCLES < 1 ||
      (p_CLOCK_FREQ_HZ % 1000000) != 0) begin : g_bad_params
    $error("eth_phy_reset_sequencer: every phase must last at least one cycle and the clock must be a whole number of MHz");
  end

  typedef enum logic [1:0] {
    S_PHY_RST  = 2'd0,
    S_SETTLE   = 2'd1,
    S_CORE_RST = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  state_t              state;
  logic [lp_CNT_W-1:0] count;

  // The state register doubles as the debug view of the sequencer.
  assign o_state = state;

  // Sequencer FSM: phase counter, phase transitions and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_PHY_RST;
      count         <= '0;
      o_phy_reset_n <= 1'b0;
      o_core_reset  <= 1'b1;
      o_ready       <= 1'b0;
      o_seq_count   <= 8'd0;
    end else begin
      case (state)
        S_PHY_RST: begin
          if (count == lp_PHY_LAST) begin
            state         <= S_SETTLE;
            count         <= '0;
            o_phy_reset_n <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_SETTLE: begin
          if (count == lp_SETTLE_LAST) begin
            state <= S_CORE_RST;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_CORE_RST: begin
          if (count == lp_CORE_LAST) begin
            state        <= S_RUN;
            count        <= '0;
            o_core_reset <= 1'b0;
            o_ready      <= 1'b1;
            if (o_seq_count != 8'hFF) begin
              o_seq_count <= o_seq_count + 8'd1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        S_RUN: begin
          count <= '0;
          if (i_soft_reset_req) begin
            state         <= S_PHY_RST;
            o_phy_reset_n <= 1'b0;
            o_core_reset  <= 1'b1;
            o_ready       <= 1'b0;
          end
        end
        default: begin
          state <= S_PHY_RST;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/eth_phy_reset_sequencer.md
Name: eth_phy_reset_sequencer

Overview:
- Power-up and soft-reset sequencer for the MII 100Base-T top level. It sits directly upstream of the Ethernet core and the PHY reset pin.
- Drives the PHY hardware reset pulse, waits out the PHY settle time, then releases the synchronous active-high core reset.
- Replaces the free-running reset counter in the top level with a timed, re-triggerable sequence that also reports status.

Parameters:
- p_CLOCK_FREQ_HZ, 125000000, frequency of i_clock in Hz. Must be a multiple of 1000000.
- p_PHY_RESET_US, 10000, PHY reset assertion time in µs. Gives lp_PHY_RST_CYCLES = p_CLOCK_FREQ_HZ/1000000*p_PHY_RESET_US.
- p_PHY_SETTLE_US, 5000, wait after PHY reset release in µs. Gives lp_SETTLE_CYCLES, computed the same way.
- p_CORE_RESET_CYCLES, 16, extra cycles core reset is held after settle. Must be ≥1.

Ports:
- i_clock, input, 1, reference clock; all logic runs on its rising edge.
- i_reset_n, input, 1, asynchronous active-low reset. Asserting it forces all outputs to reset values immediately.
- i_soft_reset_req, input, 1, synchronous one-cycle request to re-run the full sequence. Honoured only in RUN.
- o_phy_reset_n, output, 1, PHY hardware reset, active low, registered.
- o_core_reset, output, 1, synchronous active-high reset to the Ethernet core, registered.
- o_ready, output, 1, high only in RUN, registered.
- o_state, output, 2, current state encoding: 0 PHY_RST, 1 SETTLE, 2 CORE_RST, 3 RUN.
- o_seq_count, output, 8, number of completed sequences, saturating at 255.

Behaviour:
- Reset values: state PHY_RST, o_phy_reset_n=0, o_core_reset=1, o_ready=0, o_seq_count=0, internal counter=0.
- The internal counter is sized $clog2 of the largest of the three cycle counts, plus 1 bit. All counts are ≥1; otherwise the design fails elaboration via an assertion.
- PHY_RST:
  - Counter increments each edge.
  - On the edge where counter == lp_PHY_RST_CYCLES-1: state→SETTLE, counter→0, o_phy_reset_n→1.
  - o_phy_reset_n is therefore low for exactly lp_PHY_RST_CYCLES rising edges after reset release or sequence start.
- SETTLE:
  - On counter == lp_SETTLE_CYCLES-1: state→CORE_RST, counter→0.
  - o_core_reset stays 1.
- CORE_RST:
  - On counter == p_CORE_RESET_CYCLES-1: state→RUN, counter→0.
  - On the same edge: o_core_reset→0, o_ready→1, o_seq_count→min(o_seq_count+1, 255).
- RUN:
  - Counter is held at 0.
  - On an edge with i_soft_reset_req=1: state→PHY_RST.
  - On that same edge: o_phy_reset_n→0, o_core_reset→1, o_ready→0.
  - The full sequence then repeats with identical timing.
- i_soft_reset_req in PHY_RST, SETTLE or CORE_RST is ignored; it does not restart or extend the sequence.
- Total latency from reset release, or from the accepting edge, to o_core_reset=0 is lp_PHY_RST_CYCLES + lp_SETTLE_CYCLES + p_CORE_RESET_CYCLES edges.
- Reset mid-operation: asserting i_reset_n in any state returns immediately (asynchronously) to reset values. o_seq_count is cleared. On release, the sequence starts from the beginning.
- o_seq_count saturation: at 255, further completions leave it at 255.
- There are no combinational paths from inputs to outputs.

Test Plan:
- Bench parameters for all scenarios: p_CLOCK_FREQ_HZ=1000000, p_PHY_RESET_US=10, p_PHY_SETTLE_US=5, p_CORE_RESET_CYCLES=4. This gives 10/5/4 cycles.
- Reset release, then count edges:
  - o_phy_reset_n rises at edge 10.
  - o_state goes 0→1 at edge 10, 1→2 at edge 15, 2→3 at edge 19.
  - o_core_reset falls and o_ready rises at edge 19; o_seq_count=1.
- Pulse i_soft_reset_req in RUN at edge E:
  - o_phy_reset_n=0, o_core_reset=1 and o_ready=0 after edge E.
  - o_phy_reset_n returns high at E+10; o_ready returns high at E+19; o_seq_count=2.
- Pulse i_soft_reset_req at edge 5 (PHY_RST) and again at edge 17 (CORE_RST) -> timing is unchanged from scenario 2: RUN at edge 19, o_seq_count=1.
- Assert i_reset_n low at edge 12 (SETTLE) with o_seq_count=3 -> immediately o_phy_reset_n=0, o_core_reset=1, o_state=0, o_seq_count=0. After release the timing is identical to scenario 2.
- Issue 260 soft requests, each after RUN is reached -> o_seq_count reaches 255 and stays 255. o_ready=1 after the final sequence.
